// File: rtl/sdiv_pkg.sv
// Shared types and constants for the sequential signed divider sdiv16x8.
package sdiv_pkg;

  localparam int unsigned DIVIDEND_W_DEF = 16;
  localparam int unsigned DIVISOR_W_DEF  = 8;

  localparam logic [DIVISOR_W_DEF-1:0] Q_MAX = 8'h7F;
  localparam logic [DIVISOR_W_DEF-1:0] Q_MIN = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell shared with the mult8bw multiplier array.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/trial_sub9.sv
// Ripple trial subtractor a - b built from full_adder cells; o_nonneg is the no-borrow flag.
module trial_sub9 #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_nonneg
);

  logic [W:0] w_c;

  // a + ~b + 1: carry-out set means a >= b for unsigned operands
  assign w_c[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .i_a (i_a[i]),
      .i_b (~i_b[i]),
      .i_c (w_c[i]),
      .o_s (o_diff[i]),
      .o_c (w_c[i+1])
    );
  end

  assign o_nonneg = w_c[W];

endmodule

// File: rtl/sdiv16x8.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per cycle,
// sign fix-up and saturation in a final cycle, valid/ready on both sides.
module sdiv16x8
  import sdiv_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVISOR_W-1:0]  quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero,
  output logic                  ovf
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W);
  localparam int unsigned RW    = DIVISOR_W + 1;

  if ((DIVIDEND_W != 2 * DIVISOR_W) || (DIVISOR_W != DIVISOR_W_DEF)) begin : g_bad_width
    $error("sdiv16x8: DIVIDEND_W must be 2*DIVISOR_W and DIVISOR_W must match Q_MAX/Q_MIN width");
  end

  state_t                r_state;
  logic [DIVIDEND_W-1:0] r_a_mag;
  logic [DIVIDEND_W-1:0] r_q;
  logic [DIVISOR_W-1:0]  r_b_mag;
  logic [DIVISOR_W-1:0]  r_rem;
  logic [DIVISOR_W-1:0]  r_dlo;
  logic                  r_sa;
  logic                  r_sb;
  logic                  r_dz;
  logic [CNT_W-1:0]      r_cnt;

  logic [DIVIDEND_W-1:0] w_a_abs;
  logic [DIVISOR_W-1:0]  w_b_abs;
  logic [RW-1:0]         w_shift;
  logic [RW-1:0]         w_diff;
  logic                  w_nonneg;
  logic                  w_qs;
  logic [DIVISOR_W-1:0]  w_q_lo;
  logic [DIVISOR_W-1:0]  w_q_fix;
  logic [DIVISOR_W-1:0]  w_r_fix;
  logic                  w_ovf;
  logic                  w_unused;

  // -32768 and -128 negate to 0x8000 / 0x80, which are correct as unsigned magnitudes
  assign w_a_abs = dividend[DIVIDEND_W-1] ? ('0 - dividend) : dividend;
  assign w_b_abs = divisor[DIVISOR_W-1]   ? ('0 - divisor)  : divisor;

  assign w_shift = {r_rem, r_a_mag[DIVIDEND_W-1]};

  trial_sub9 #(
    .W (RW)
  ) u_sub (
    .i_a      (w_shift),
    .i_b      ({1'b0, r_b_mag}),
    .o_diff   (w_diff),
    .o_nonneg (w_nonneg)
  );

  // A kept difference is below |divisor| <= 128, so its top bit is always clear
  assign w_unused = w_diff[DIVISOR_W];

  assign w_qs    = r_sa ^ r_sb;
  assign w_q_lo  = r_q[DIVISOR_W-1:0];
  assign w_q_fix = w_qs ? ('0 - w_q_lo) : w_q_lo;
  assign w_r_fix = r_sa ? ('0 - r_rem) : r_rem;
  assign w_ovf   = w_qs ? (r_q > DIVIDEND_W'(Q_MIN)) : (r_q > DIVIDEND_W'(Q_MAX));

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a_mag   <= '0;
      r_q       <= '0;
      r_b_mag   <= '0;
      r_rem     <= '0;
      r_dlo     <= '0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_dz      <= 1'b0;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_mag <= w_a_abs;
            r_b_mag <= w_b_abs;
            r_sa    <= dividend[DIVIDEND_W-1];
            r_sb    <= divisor[DIVISOR_W-1];
            r_dz    <= (divisor == '0);
            r_dlo   <= dividend[DIVISOR_W-1:0];
            r_q     <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= ITER;
          end
        end
        ITER: begin
          r_rem   <= w_nonneg ? w_diff[DIVISOR_W-1:0] : w_shift[DIVISOR_W-1:0];
          r_q     <= {r_q[DIVIDEND_W-2:0], w_nonneg};
          r_a_mag <= {r_a_mag[DIVIDEND_W-2:0], 1'b0};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DIVIDEND_W - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          if (r_dz) begin
            quotient  <= r_sa ? Q_MIN : Q_MAX;
            remainder <= r_dlo;
            div_zero  <= 1'b1;
            ovf       <= 1'b0;
          end else if (w_ovf) begin
            quotient  <= w_qs ? Q_MIN : Q_MAX;
            remainder <= '0;
            div_zero  <= 1'b0;
            ovf       <= 1'b1;
          end else begin
            quotient  <= w_q_fix;
            remainder <= w_r_fix;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
          end
          r_state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdiv16x8.sv
// Directed-vector bench for sdiv16x8: results, flags, latency, backpressure and async reset.
module tb_sdiv16x8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_zero;
  logic        ovf;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  sdiv16x8 #(
    .DIVIDEND_W (16),
    .DIVISOR_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // {dividend, divisor, quotient, remainder, div_zero, ovf}
  logic [41:0] vt [18] = '{
    {16'hFED4, 8'h07, 8'hD6, 8'hFA, 1'b0, 1'b0},  // -300 / 7
    {16'h4000, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0},  // 16384 / -128 = -128 fits
    {16'hC000, 8'h80, 8'h7F, 8'h00, 1'b0, 1'b1},  // -16384 / -128 = 128 ovf
    {16'h1234, 8'h00, 8'h7F, 8'h34, 1'b1, 1'b0},  // divide by zero, dividend >= 0
    {16'h8000, 8'hFF, 8'h7F, 8'h00, 1'b0, 1'b1},  // -32768 / -1
    {16'h8000, 8'h00, 8'h80, 8'h00, 1'b1, 1'b0},  // divide by zero, dividend < 0
    {16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0},  // 100 / 7
    {16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0},  // -100 / -7
    {16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0},  // 100 / -7
    {16'h3F80, 8'h80, 8'h81, 8'h00, 1'b0, 1'b0},  // 16256 / -128 = -127
    {16'h3F81, 8'h7F, 8'h7F, 8'h00, 1'b0, 1'b1},  // 16257 / 127 = 128 ovf
    {16'hC080, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0},  // -16256 / 127 = -128 fits
    {16'hC07F, 8'h7F, 8'h80, 8'hFF, 1'b0, 1'b0},  // -16257 / 127 = -128 r -1
    {16'h0005, 8'h07, 8'h00, 8'h05, 1'b0, 1'b0},
    {16'hFFFB, 8'h07, 8'h00, 8'hFB, 1'b0, 1'b0},
    {16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0},
    {16'h7FFF, 8'h7F, 8'h7F, 8'h00, 1'b0, 1'b1},  // 32767 / 127 = 258 ovf
    {16'h0000, 8'h00, 8'h7F, 8'h00, 1'b1, 1'b0}
  };

  int prod_a [8] = '{-128, -127, -1, 0, 1, 5, 77, 127};
  int prod_b [6] = '{-128, -1, 1, 3, 127, -77};

  task automatic start_op(input logic [15:0] a, input logic [7:0] b, input string tag);
    int g;
    g = 0;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    chk({tag, ".busy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'd17);
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_vec(input logic [15:0] a, input logic [7:0] b, input logic [7:0] eq,
                        input logic [7:0] er, input logic edz, input logic eov, input string tag);
    start_op(a, b, tag);
    wait_done(tag);
    chk({tag, ".q"},   32'(quotient),  32'(eq));
    chk({tag, ".r"},   32'(remainder), 32'(er));
    chk({tag, ".dz"},  32'(div_zero),  32'(edz));
    chk({tag, ".ovf"}, 32'(ovf),       32'(eov));
    finish_op();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".q"},         32'(quotient),  32'd0);
    chk({tag, ".r"},         32'(remainder), 32'd0);
    chk({tag, ".dz"},        32'(div_zero),  32'd0);
    chk({tag, ".ovf"},       32'(ovf),       32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  eq;
    logic [7:0]  er;
    logic        edz;
    logic        eov;

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1 rst = 1'b1;
    #3;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      {a, b, eq, er, edz, eov} = vt[i];
      do_vec(a, b, eq, er, edz, eov, $sformatf("vec%0d", i));
    end

    // products of the multiplier always divide back exactly
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 6; j++) begin
        a = 16'(prod_a[i] * prod_b[j]);
        b = 8'(prod_b[j]);
        do_vec(a, b, 8'(prod_a[i]), 8'h00, 1'b0, 1'b0, $sformatf("prod%0d_%0d", prod_a[i], prod_b[j]));
      end
    end

    // backpressure: hold result in DONE with a new request already waiting
    start_op(16'hFED4, 8'h07, "bp");
    wait_done("bp");
    @(negedge clk);
    dividend = 16'h0064;
    divisor  = 8'h07;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp.hold%0d.q", k),        32'(quotient),  32'hD6);
      chk($sformatf("bp.hold%0d.r", k),        32'(remainder), 32'hFA);
      chk($sformatf("bp.hold%0d.valid", k),    32'(out_valid), 32'd1);
      chk($sformatf("bp.hold%0d.in_ready", k), 32'(in_ready),  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.idle.in_ready", 32'(in_ready),  32'd1);
    chk("bp.idle.valid",    32'(out_valid), 32'd0);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("bp.accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
    wait_done("bp2");
    chk("bp2.q", 32'(quotient),  32'h0E);
    chk("bp2.r", 32'(remainder), 32'h02);
    finish_op();

    // asynchronous reset in the middle of the iterations
    start_op(16'h1234, 8'h07, "rstmid");
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("rstmid");
    @(negedge clk);
    rst = 1'b0;
    do_vec(16'hFED4, 8'h07, 8'hD6, 8'hFA, 1'b0, 1'b0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdiv16x8.md
# sdiv16x8

Sequential signed divider: 16-bit two's-complement dividend by 8-bit two's-complement divisor, producing an 8-bit quotient and 8-bit remainder. It is the inverse datapath of the team's combinational 8x8 Baugh-Wooley multiplier `mult8bw`: feeding `p = a*b` and `b` returns `a` with remainder 0. It uses unsigned restoring division on magnitudes with a valid/ready handshake on both sides and fixed latency.

## Interface
- `DIVIDEND_W`, default 16: dividend width. It must equal 2*`DIVISOR_W`.
- `DIVISOR_W`, default 8: divisor, quotient and remainder width.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in_valid`, input, 1: operands are valid.
- `in_ready`, output, 1: the block can accept operands. High only in IDLE.
- `dividend`, input, `DIVIDEND_W`: signed dividend.
- `divisor`, input, `DIVISOR_W`: signed divisor.
- `out_valid`, output, 1: result is valid. High only in DONE.
- `out_ready`, input, 1: the consumer accepts the result.
- `quotient`, output, `DIVISOR_W`: signed quotient, truncated toward zero.
- `remainder`, output, `DIVISOR_W`: signed remainder. It carries the sign of the dividend.
- `div_zero`, output, 1: the divisor was 0.
- `ovf`, output, 1: the true quotient falls outside -128..127.

## Operation
- **States:** IDLE, ITER, FIX, DONE. Reset state is IDLE.
- **Output reset values:** `in_ready`=1, `out_valid`=0, `quotient`=0, `remainder`=0, `div_zero`=0, `ovf`=0.
- **IDLE:**
  - Accept when `in_valid & in_ready`.
  - Register |dividend| (17-bit safe, so -32768 gives 32768), |divisor| (9-bit), both sign bits, and a zero-divisor flag.
  - Clear the 16-bit quotient shift register and the 9-bit partial remainder. Set cnt=0. Go to ITER.
- **ITER, one bit per cycle, MSB first:**
  - Shift the next dividend bit into the partial remainder.
  - Trial-subtract |divisor|. If the result is non-negative, keep it and shift 1 into the quotient; otherwise shift 0.
  - After `DIVIDEND_W` iterations go to FIX. A zero divisor still runs all iterations; the results are discarded.
- **FIX, one cycle:**
  - qs = sign_a ^ sign_b. Apply qs to the magnitude quotient and sign_a to the magnitude remainder.
  - If div_zero: `quotient` = 0x7F when dividend ≥ 0, else 0x80. `remainder` = dividend[7:0]. `ovf`=0.
  - Else if magnitude quotient > 127 (qs=0) or > 128 (qs=1): `ovf`=1. `quotient` saturates to 0x7F (qs=0) or 0x80 (qs=1). `remainder`=0.
  - Else: exact result. Invariant: quotient*divisor + remainder == dividend.
  - Go to DONE.
- **DONE:**
  - Outputs hold stable while `out_valid`=1.
  - On `out_ready`, go to IDLE. Outputs keep their last values until the next FIX.
- **Backpressure:** `in_valid` has no effect outside IDLE. Operand ports are sampled only at the accept edge and may change afterwards.
- **Reset mid-operation:** asserting `rst` forces IDLE and all reset values asynchronously. Any partial result is lost.

## Timing
- Accept at edge N. ITER runs edges N+1..N+16. FIX is edge N+17. `out_valid`=1 from edge N+17.
- Latency: 17 cycles, independent of operand values, `div_zero` and `ovf`.
- Minimum initiation interval: 19 cycles (accept, 16 ITER, FIX, DONE with `out_ready`=1, then IDLE).
- DONE→IDLE and a new accept never happen on the same edge: `in_ready` is 0 in DONE.
- `in_ready` and `out_valid` decode directly from state registers, with no combinational path from inputs.

## Structure
- **Package `sdiv_pkg`:** state enum {IDLE, ITER, FIX, DONE}, `DIVIDEND_W`/`DIVISOR_W` defaults, and the saturation constants `Q_MAX`=0x7F and `Q_MIN`=0x80.
- **Sub-module `trial_sub9`:** combinational 9-bit subtractor that takes the partial remainder and |divisor| and returns difference and non-negative flag. Build it from the existing `full_adder` cells so it matches the multiplier's gate style.
- **Top level:** FSM, counter, shift registers and sign fix-up.

## Test plan
- dividend=0xFED4 (-300), divisor=0x07 → after 17 cycles: `quotient`=0xD6 (-42), `remainder`=0xFA (-6), flags 0.
- dividend=0x4000 (16384), divisor=0x80 (-128) → `quotient`=0x80, `remainder`=0x00, `ovf`=0 (boundary fits). dividend=0xC000, divisor=0x80 → `quotient`=0x7F, `ovf`=1.
- dividend=0x1234, divisor=0x00 → `div_zero`=1, `quotient`=0x7F, `remainder`=0x34, `ovf`=0, still 17-cycle latency.
- Hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0. Keep `in_valid`=1 throughout. The second operand pair is accepted exactly one cycle after `out_ready` rises.
- Assert `rst` at ITER cycle 8 → immediate IDLE, `in_ready`=1, all outputs 0. A fresh operation then completes correctly.
- Random sweep of 10k pairs, plus all pairs p = a*b from the `mult8bw` model → invariant holds, or flags are set exactly per the FIX rules. `remainder`=0 and `quotient`=a for every multiplier-product pair with b≠0 that does not overflow.
